// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate controller: arbitrates entrance/exit lanes, checks the
// entry code with attempt limiting and lockout, and tracks car park occupancy.
module parking_gate_arbiter #(
    parameter int         CAPACITY     = 8,
    parameter logic [3:0] PASSWORD     = 4'b1011,
    parameter int         OPEN_CYCLES  = 16,
    parameter int         PASS_TIMEOUT = 32,
    parameter int         MAX_TRIES    = 3,
    parameter int         LOCK_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic [3:0] password,
    input  logic       pass_valid,
    input  logic       car_passed,
    output logic       gate_open,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic [2:0] indicator,
    output logic [3:0] countcar,
    output logic       full
);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        WAIT_PASS  = 3'b001,
        ENTRY_OPEN = 3'b010,
        EXIT_OPEN  = 3'b011,
        LOCKOUT    = 3'b100
    } state_t;

    localparam int MAX_AB    = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
    localparam int TIMER_MAX = (MAX_AB > LOCK_CYCLES) ? MAX_AB : LOCK_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX);
    localparam int NW        = $clog2(MAX_TRIES + 1);

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [NW-1:0]   tries, tries_n, tries_inc;
    logic            wrong_flag, wrong_n;
    logic            last_served, last_n;
    logic [3:0]      count_n;
    logic            full_n;
    logic            exit_ok, entry_ok;

    // Next-state logic; outputs are registered from these next values so they
    // track the state on the same edge the state changes.
    always_comb begin
        state_n   = state;
        timer_n   = timer + TW'(1);
        tries_n   = tries;
        tries_inc = tries + NW'(1);
        wrong_n   = wrong_flag;
        last_n    = last_served;
        count_n   = countcar;
        exit_ok   = sensor_exit && (countcar != 4'd0);
        entry_ok  = sensor_entrance && !full;

        case (state)
            IDLE: begin
                if (exit_ok && (!entry_ok || !last_served)) begin
                    state_n = EXIT_OPEN;
                end else if (entry_ok) begin
                    state_n = WAIT_PASS;
                end
            end
            WAIT_PASS: begin
                if (pass_valid) begin
                    if (password == PASSWORD) begin
                        state_n = ENTRY_OPEN;
                        tries_n = '0;
                        wrong_n = 1'b0;
                    end else if (tries_inc >= NW'(MAX_TRIES)) begin
                        state_n = LOCKOUT;
                        tries_n = tries_inc;
                        wrong_n = 1'b0;
                    end else begin
                        tries_n = tries_inc;
                        wrong_n = 1'b1;
                        timer_n = '0;
                    end
                end else if ((timer == TW'(PASS_TIMEOUT - 1)) || !sensor_entrance) begin
                    state_n = IDLE;
                    tries_n = '0;
                    wrong_n = 1'b0;
                end
            end
            ENTRY_OPEN: begin
                last_n = 1'b0;
                if (car_passed) begin
                    if (countcar < 4'(CAPACITY)) begin
                        count_n = countcar + 4'd1;
                    end
                    state_n = IDLE;
                end else if (timer == TW'(OPEN_CYCLES - 1)) begin
                    state_n = IDLE;
                end
            end
            EXIT_OPEN: begin
                last_n = 1'b1;
                if (car_passed) begin
                    if (countcar != 4'd0) begin
                        count_n = countcar - 4'd1;
                    end
                    state_n = IDLE;
                end else if (timer == TW'(OPEN_CYCLES - 1)) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    state_n = IDLE;
                    tries_n = '0;
                    wrong_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n != state) begin
            timer_n = '0;
        end
        full_n = (count_n == 4'(CAPACITY));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            tries       <= '0;
            wrong_flag  <= 1'b0;
            last_served <= 1'b1;
            countcar    <= 4'd0;
            full        <= 1'b0;
            gate_open   <= 1'b0;
            GREEN_LED   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            RED_LED     <= 1'b0;
            indicator   <= 3'b000;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            tries       <= tries_n;
            wrong_flag  <= wrong_n;
            last_served <= last_n;
            countcar    <= count_n;
            full        <= full_n;
            gate_open   <= (state_n == ENTRY_OPEN) || (state_n == EXIT_OPEN);
            GREEN_LED   <= (state_n == ENTRY_OPEN) || (state_n == EXIT_OPEN);
            grant_entry <= (state_n == ENTRY_OPEN);
            grant_exit  <= (state_n == EXIT_OPEN);
            RED_LED     <= full_n || (state_n == LOCKOUT) || ((state_n == WAIT_PASS) && wrong_n);
            indicator   <= state_n;
        end
    end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: a vector table for basic traffic
// plus hand sequences for filling, lockout, tie alternation, timeouts and reset.
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance, sensor_exit, pass_valid, car_passed;
    logic [3:0] password;
    logic       gate_open, grant_entry, grant_exit, GREEN_LED, RED_LED, full;
    logic [2:0] indicator;
    logic [3:0] countcar;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ent;
        logic       ex;
        logic [3:0] pw;
        logic       pv;
        logic       cp;
        logic [2:0] ind;
        logic [3:0] cnt;
        logic       red;
    } vec_t;

    vec_t vecs[15];

    parking_gate_arbiter dut (
        .clk(clk), .reset(reset),
        .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
        .password(password), .pass_valid(pass_valid), .car_passed(car_passed),
        .gate_open(gate_open), .grant_entry(grant_entry), .grant_exit(grant_exit),
        .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .indicator(indicator),
        .countcar(countcar), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check1(input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", what, act, exp);
        end
    endtask

    // Drive one cycle of inputs and sample outputs 1 time unit after the edge.
    task automatic applyStimulus(input logic ent, input logic ex, input logic [3:0] pw,
                                 input logic pv, input logic cp);
        sensor_entrance = ent;
        sensor_exit     = ex;
        password        = pw;
        pass_valid      = pv;
        car_passed      = cp;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int ind, input int cnt, input int red);
        int open_exp;
        open_exp = (ind == 2 || ind == 3) ? 1 : 0;
        check1({name, " indicator"}, int'(indicator), ind);
        check1({name, " gate_open"}, int'(gate_open), open_exp);
        check1({name, " GREEN_LED"}, int'(GREEN_LED), open_exp);
        check1({name, " grant_entry"}, int'(grant_entry), (ind == 2) ? 1 : 0);
        check1({name, " grant_exit"}, int'(grant_exit), (ind == 3) ? 1 : 0);
        check1({name, " countcar"}, int'(countcar), cnt);
        check1({name, " full"}, int'(full), (cnt == 8) ? 1 : 0);
        check1({name, " RED_LED"}, int'(RED_LED), red);
    endtask

    task automatic enterCar(input int cnt_before);
        int after;
        after = cnt_before + 1;
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("enter_req", 1, cnt_before, 0);
        applyStimulus(1'b1, 1'b0, 4'b1011, 1'b1, 1'b0);
        checkOutput("enter_code", 2, cnt_before, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("enter_pass", 0, after, (after == 8) ? 1 : 0);
    endtask

    task automatic exitCar(input int cnt_before);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("exit_req", 3, cnt_before, (cnt_before == 8) ? 1 : 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("exit_pass", 0, cnt_before - 1, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd2, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd1, 4'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 3'd1, 4'd1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd2, 4'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0, 4'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd3, 4'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 4'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd1, 4'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 3'd1, 4'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd1, 1'b0};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("reset", 0, 0, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("post_reset_idle", 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ent, vecs[i].ex, vecs[i].pw, vecs[i].pv, vecs[i].cp);
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].ind), int'(vecs[i].cnt), int'(vecs[i].red));
        end

        // Fill the car park, then confirm a full lot rejects entry but serves exit.
        for (int c = 1; c < 8; c++) enterCar(c);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            checkOutput("full_reject", 0, 8, 1);
        end
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("full_exit_req", 3, 8, 1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("full_exit_pass", 0, 7, 0);

        // Three wrong codes lead to a lockout of exactly 64 cycles.
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("lock_req", 1, 7, 0);
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("wrong1", 1, 7, 1);
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("wrong2", 1, 7, 1);
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("wrong3_lock", 4, 7, 1);
        for (int i = 1; i < 64; i++) begin
            applyStimulus(1'b1, 1'b1, 4'b1011, 1'b1, 1'b1);
            checkOutput($sformatf("lock_hold%0d", i), 4, 7, 1);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("lock_release", 0, 7, 0);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("retry_req", 1, 7, 0);
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("retry_wrong1", 1, 7, 1);
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        checkOutput("retry_wrong2", 1, 7, 1);
        applyStimulus(1'b1, 1'b0, 4'b1011, 1'b1, 1'b0);
        checkOutput("retry_ok", 2, 7, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("retry_pass", 0, 8, 1);

        for (int c = 8; c > 3; c--) exitCar(c);

        // Tie arbitration alternates, starting with entry since exit was served last.
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("tie1_entry", 1, 3, 0);
        applyStimulus(1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
        checkOutput("tie1_code", 2, 3, 0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("tie1_pass", 0, 4, 0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("tie2_exit", 3, 4, 0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
        checkOutput("tie2_pass", 0, 3, 0);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("tie3_entry", 1, 3, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("tie3_drop", 0, 3, 0);

        // Gate-open window closes after 16 cycles with no car.
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("open_to_req", 1, 3, 0);
        applyStimulus(1'b1, 1'b0, 4'b1011, 1'b1, 1'b0);
        checkOutput("open_to_code", 2, 3, 0);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
            checkOutput($sformatf("open_hold%0d", i), 2, 3, 0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("open_timeout", 0, 3, 0);

        // Code entry window expires after 32 cycles.
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("pass_to_req", 1, 3, 0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
            checkOutput($sformatf("pass_hold%0d", i), 1, 3, 0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("pass_timeout", 0, 3, 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("pass_idle", 0, 3, 0);

        // Reset while the exit gate is open.
        enterCar(3);
        enterCar(4);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("rst_exit_open", 3, 5, 0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        checkOutput("rst_mid", 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
            checkOutput("empty_exit_ignored", 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
